ram_access_ctrl: RTL

- Initiator side of the single-port synchronous RAM interface: drives address, write_en and write_data, and consumes read_data, which has 1-cycle registered latency.
- Converts a valid/ready request stream from the CPU datapath into RAM port cycles.
- Captures read results into a held response register with valid/ready backpressure.
- Provides a hardware zero-fill of the whole RAM after reset and on command.

---
 rtl/ram_access_ctrl_if.sv | 40 ++++
 rtl/ram_access_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ram_access_ctrl_if.sv
// CPU-side request/response bundle for ram_access_ctrl.
// master = CPU datapath issuing requests, slave = the controller.
interface ram_access_ctrl_if #(
  parameter int unsigned SIZE = 16,
  parameter int unsigned AW   = 8
);

  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [AW-1:0]   req_addr;
  logic [SIZE-1:0] req_wdata;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [SIZE-1:0] rsp_data;

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/ram_access_ctrl.sv
// Initiator for a single-port synchronous RAM with 1-cycle read latency:
// valid/ready request stream in, held read response out, plus hardware zero-fill.
module ram_access_ctrl #(
  parameter int unsigned SIZE  = 16,
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     clear_start_i,
  output logic                     clear_busy_o,

  ram_access_ctrl_if.slave         bus,

  output logic [$clog2(DEPTH)-1:0] ram_address_o,
  output logic                     ram_write_en_o,
  output logic [SIZE-1:0]          ram_write_data_o,
  input  logic [SIZE-1:0]          ram_read_data_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  localparam logic [1:0] StClear  = 2'd0;
  localparam logic [1:0] StIdle   = 2'd1;
  localparam logic [1:0] StRdWait = 2'd2;
  localparam logic [1:0] StRsp    = 2'd3;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gen_bad_depth
    $error("ram_access_ctrl: DEPTH must be a power of two and at least 2");
  end

  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [SIZE-1:0] rsp_data_q, rsp_data_d;

  logic req_fire;
  logic rd_accept;
  logic rsp_fire;

  // clear_start wins over a simultaneous request, so it also gates req_ready.
  assign req_fire  = (state_q == StIdle) && !clear_start_i && bus.req_valid;
  assign rd_accept = req_fire && !bus.req_write;
  assign rsp_fire  = (state_q == StRsp) && bus.rsp_ready;

  always_comb begin
    clear_busy_o  = (state_q == StClear);
    bus.req_ready = (state_q == StIdle) && !clear_start_i;
    bus.rsp_valid = (state_q == StRsp);
    bus.rsp_data  = rsp_data_q;
  end

  always_comb begin
    ram_address_o    = rd_addr_q;
    ram_write_en_o   = 1'b0;
    ram_write_data_o = '0;
    case (state_q)
      StClear: begin
        ram_address_o    = cnt_q;
        ram_write_en_o   = 1'b1;
        ram_write_data_o = '0;
      end
      StIdle: begin
        ram_address_o    = bus.req_addr;
        ram_write_en_o   = req_fire && bus.req_write;
        ram_write_data_o = bus.req_wdata;
      end
      default: begin
        ram_address_o    = rd_addr_q;
        ram_write_en_o   = 1'b0;
        ram_write_data_o = '0;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_addr_d  = rd_addr_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      StClear: begin
        // DEPTH is a power of two, so the increment wraps back to 0 at the last entry.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastAddr) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (clear_start_i) begin
          state_d = StClear;
          cnt_d   = '0;
        end else if (rd_accept) begin
          state_d   = StRdWait;
          rd_addr_d = bus.req_addr;
        end
      end
      StRdWait: begin
        rsp_data_d = ram_read_data_i;
        state_d    = StRsp;
      end
      StRsp: begin
        if (rsp_fire) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StClear;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StClear;
      cnt_q      <= '0;
      rd_addr_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_addr_q  <= rd_addr_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  a_rsp_hold: assert property (@(posedge clk) disable iff (rst)
    bus.rsp_valid && !bus.rsp_ready |=> bus.rsp_valid && $stable(bus.rsp_data));

  a_ready_excl: assert property (@(posedge clk) disable iff (rst)
    !(bus.req_ready && (clear_busy_o || bus.rsp_valid)));

  a_we_legal: assert property (@(posedge clk) disable iff (rst)
    ram_write_en_o |-> (state_q == StClear) || (state_q == StIdle));

  a_cnt_idle: assert property (@(posedge clk) disable iff (rst)
    (state_q != StClear) |-> (cnt_q == '0));

endmodule
